mc_fsm_ctrl: RTL and testbench

Hardwired multi-cycle control unit for the single-memory MIPS datapath. It drives the same control lines as the microprogrammed controller, so the two are drop-in alternatives. It adds an asynchronous reset, a memory-ready wait handshake, an illegal-opcode trap and a retired-instruction counter. It sits beside the datapath: it takes the opcode from the instruction register and drives PC, IR, register-file, ALU-source and memory controls.

---
 rtl/mc_fsm_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mc_fsm_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// mc_fsm_ctrl
//
// Hardwired multi-cycle control unit for the single-memory MIPS datapath.
// It drives the same control lines as the microprogrammed controller, so the
// two are interchangeable. On top of the classic FSM it adds a memory-ready
// wait handshake, a sticky illegal-opcode trap and a retired-instruction
// counter.
//
// Parameters
//   WAIT_EN    1 = FETCH/MRD/MWR stall until mem_ready, 0 = every access
//              completes in one cycle and mem_ready is ignored
//   CNT_W      width of the retired-instruction counter (wraps)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   Op         opcode field Inst[31:26] from the instruction register
//   mem_ready  memory completes the current access this cycle
//   PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, ALUSrcA, RegWr,
//   RegDst     single-bit datapath controls
//   PCSrc      00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp      00 add, 01 sub, 10 use funct
//   ALUSrcB    00 B, 01 const 4, 10 SigExt, 11 SigExt<<2
//   state      current state code (debug)
//   illegal    sticky trap flag, cleared only by rst
//   retired    count of completed instructions
// ---------------------------------------------------------------------------
module mc_fsm_ctrl #(
    parameter int WAIT_EN = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic             IorD,
    output logic             MemRd,
    output logic             MemWr,
    output logic             IRWr,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic             RegWr,
    output logic             RegDst,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // Supported opcodes
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // State codes are visible on the debug port, so they are fixed values
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_IEXE   = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    // Moore part of the control word. IRWr and the FETCH contribution to
    // PCWr depend on mem_ready and are added outside this bundle.
    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_wr;
        logic       reg_dst;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

    state_t           state_q;
    state_t           state_nxt;
    ctrl_t            ctrl_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             ready;
    logic             fetch_go;
    logic             retire_evt;
    logic             run;

    // Control word for each state; every bit not named for a state stays 0
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_rd    = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_MADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MRD: begin
                c.mem_rd = 1'b1;
                c.i_or_d = 1'b1;
            end
            S_MWB: begin
                c.reg_wr     = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MWR: begin
                c.mem_wr = 1'b1;
                c.i_or_d = 1'b1;
            end
            S_REXE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RWB: begin
                c.reg_wr  = 1'b1;
                c.reg_dst = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = 2'b01;
                c.pc_wr_cond = 1'b1;
                c.pc_src     = 2'b01;
            end
            S_JMP: begin
                c.pc_wr  = 1'b1;
                c.pc_src = 2'b10;
            end
            S_IEXE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_IWB: begin
                c.reg_wr = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // With the handshake disabled every memory access is treated as ready
    assign ready = (WAIT_EN != 0) ? mem_ready : 1'b1;

    // Instruction fetch completes this cycle: IR and PC are written together
    assign fetch_go = (state_q == S_FETCH) && ready;

    // An instruction retires on the edge that leaves its final state
    always_comb begin
        retire_evt = 1'b0;
        case (state_q)
            S_MWB, S_RWB, S_BEQ, S_JMP, S_IWB: retire_evt = 1'b1;
            S_MWR:                             retire_evt = ready;
            default:                           retire_evt = 1'b0;
        endcase
    end

    // Next-state logic. Op is only looked at in DECODE and MADDR; the
    // instruction register is stable from the end of FETCH onwards.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_FETCH: begin
                if (ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MADDR;
                    OP_R:         state_nxt = S_REXE;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_J:         state_nxt = S_JMP;
                    OP_ADDI:      state_nxt = S_IEXE;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MADDR: begin
                if (Op == OP_LW)      state_nxt = S_MRD;
                else if (Op == OP_SW) state_nxt = S_MWR;
                else                  state_nxt = S_TRAP;
            end
            S_MRD: begin
                if (ready) state_nxt = S_MWB;
            end
            S_MWR: begin
                if (ready) state_nxt = S_FETCH;
            end
            S_MWB, S_RWB, S_BEQ, S_JMP, S_IWB: begin
                state_nxt = S_FETCH;
            end
            S_REXE: begin
                state_nxt = S_RWB;
            end
            S_IEXE: begin
                state_nxt = S_IWB;
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                // Unused codes are unreachable; treat a corrupted state as a trap
                state_nxt = S_TRAP;
            end
        endcase
    end

    // State, registered Moore controls, trap flag and retire counter. The
    // control word is decoded from the next state so it is glitch-free from
    // a flop in the cycle the state becomes current.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode_ctrl(S_FETCH);
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= decode_ctrl(state_nxt);
            if (state_nxt == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (retire_evt) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Reset forces every control low combinationally, so an access or
    // register write that was in progress is dropped in the same cycle.
    assign run = ~rst;

    assign PCWr     = run & (ctrl_q.pc_wr | fetch_go);
    assign IRWr     = run & fetch_go;
    assign PCWrCond = run & ctrl_q.pc_wr_cond;
    assign IorD     = run & ctrl_q.i_or_d;
    assign MemRd    = run & ctrl_q.mem_rd;
    assign MemWr    = run & ctrl_q.mem_wr;
    assign MemtoReg = run & ctrl_q.mem_to_reg;
    assign ALUSrcA  = run & ctrl_q.alu_src_a;
    assign RegWr    = run & ctrl_q.reg_wr;
    assign RegDst   = run & ctrl_q.reg_dst;
    assign PCSrc    = {2{run}} & ctrl_q.pc_src;
    assign ALUOp    = {2{run}} & ctrl_q.alu_op;
    assign ALUSrcB  = {2{run}} & ctrl_q.alu_src_b;

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_fsm_ctrl
//
// Self-checking bench for mc_fsm_ctrl. Instance dut_a uses the default
// parameters (wait handshake on, 32-bit counter); dut_b has the handshake
// off, mem_ready tied low and a 4-bit counter so it wraps after 16
// instructions. Each instruction is expanded into its expected per-cycle
// state walk and compared against the outputs every cycle.
// ---------------------------------------------------------------------------
module tb_mc_fsm_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    bit         use_b;

    logic       a_pc_wr, a_pc_wr_cond, a_i_or_d, a_mem_rd, a_mem_wr, a_ir_wr;
    logic       a_mem_to_reg, a_alu_src_a, a_reg_wr, a_reg_dst, a_illegal;
    logic [1:0] a_pc_src, a_alu_op, a_alu_src_b;
    logic [3:0] a_state;
    logic [31:0] a_retired;

    logic       b_pc_wr, b_pc_wr_cond, b_i_or_d, b_mem_rd, b_mem_wr, b_ir_wr;
    logic       b_mem_to_reg, b_alu_src_a, b_reg_wr, b_reg_dst, b_illegal;
    logic [1:0] b_pc_src, b_alu_op, b_alu_src_b;
    logic [3:0] b_state;
    logic [3:0] b_retired;

    int checks   = 0;
    int failures = 0;
    int model_retired;

    typedef struct {
        int code;
        bit rdy;
    } step_t;

    step_t seq[$];

    always #5 clk = ~clk;

    mc_fsm_ctrl dut_a (
        .clk(clk), .rst(rst), .Op(op), .mem_ready(mem_ready),
        .PCWr(a_pc_wr), .PCWrCond(a_pc_wr_cond), .IorD(a_i_or_d),
        .MemRd(a_mem_rd), .MemWr(a_mem_wr), .IRWr(a_ir_wr),
        .MemtoReg(a_mem_to_reg), .ALUSrcA(a_alu_src_a), .RegWr(a_reg_wr),
        .RegDst(a_reg_dst), .PCSrc(a_pc_src), .ALUOp(a_alu_op),
        .ALUSrcB(a_alu_src_b), .state(a_state), .illegal(a_illegal),
        .retired(a_retired)
    );

    mc_fsm_ctrl #(.WAIT_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .Op(op), .mem_ready(1'b0),
        .PCWr(b_pc_wr), .PCWrCond(b_pc_wr_cond), .IorD(b_i_or_d),
        .MemRd(b_mem_rd), .MemWr(b_mem_wr), .IRWr(b_ir_wr),
        .MemtoReg(b_mem_to_reg), .ALUSrcA(b_alu_src_a), .RegWr(b_reg_wr),
        .RegDst(b_reg_dst), .PCSrc(b_pc_src), .ALUOp(b_alu_op),
        .ALUSrcB(b_alu_src_b), .state(b_state), .illegal(b_illegal),
        .retired(b_retired)
    );

    // Control bundle order: PCWr PCWrCond IorD MemRd MemWr IRWr MemtoReg
    // ALUSrcA RegWr RegDst PCSrc ALUOp ALUSrcB
    wire [15:0] ctrl_a = {a_pc_wr, a_pc_wr_cond, a_i_or_d, a_mem_rd, a_mem_wr,
                          a_ir_wr, a_mem_to_reg, a_alu_src_a, a_reg_wr,
                          a_reg_dst, a_pc_src, a_alu_op, a_alu_src_b};
    wire [15:0] ctrl_b = {b_pc_wr, b_pc_wr_cond, b_i_or_d, b_mem_rd, b_mem_wr,
                          b_ir_wr, b_mem_to_reg, b_alu_src_a, b_reg_wr,
                          b_reg_dst, b_pc_src, b_alu_op, b_alu_src_b};

    wire [15:0] obs_ctrl    = use_b ? ctrl_b : ctrl_a;
    wire [3:0]  obs_state   = use_b ? b_state : a_state;
    wire        obs_illegal = use_b ? b_illegal : a_illegal;
    wire        obs_ir_wr   = use_b ? b_ir_wr : a_ir_wr;
    wire [31:0] obs_retired = use_b ? {28'd0, b_retired} : a_retired;

    // Compare one observed value with its expected value and log a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected control bundle for a state code, straight from the state table
    function automatic logic [15:0] exp_ctrl(input int code, input bit rdy);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst;
        logic [1:0] psrc, aop, srcb;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst} = '0;
        psrc = 2'b00;
        aop  = 2'b00;
        srcb = 2'b00;
        case (code)
            0:  begin mrd = 1; srcb = 2'b01; pcw = rdy; irw = rdy; end
            1:  begin srcb = 2'b11; end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin pcw = 1; psrc = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: begin rw = 1; end
            default: begin end
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst, psrc, aop, srcb};
    endfunction

    // Expand one instruction into its expected cycle-by-cycle state walk.
    // fw/mw give the number of not-ready cycles in FETCH and in the data access.
    task automatic buildSequence(input logic [5:0] opc, input int fw, input int mw);
        seq.delete();
        for (int i = 0; i < fw; i++) seq.push_back('{0, 1'b0});
        seq.push_back('{0, 1'b1});
        seq.push_back('{1, 1'($urandom)});
        case (opc)
            OP_R:    begin seq.push_back('{6, 1'($urandom)}); seq.push_back('{7, 1'($urandom)}); end
            OP_LW: begin
                seq.push_back('{2, 1'($urandom)});
                for (int i = 0; i < mw; i++) seq.push_back('{3, 1'b0});
                seq.push_back('{3, 1'b1});
                seq.push_back('{4, 1'($urandom)});
            end
            OP_SW: begin
                seq.push_back('{2, 1'($urandom)});
                for (int i = 0; i < mw; i++) seq.push_back('{5, 1'b0});
                seq.push_back('{5, 1'b1});
            end
            OP_BEQ:  seq.push_back('{8, 1'($urandom)});
            OP_J:    seq.push_back('{9, 1'($urandom)});
            OP_ADDI: begin seq.push_back('{10, 1'($urandom)}); seq.push_back('{11, 1'($urandom)}); end
            default: for (int i = 0; i < 20; i++) seq.push_back('{15, 1'($urandom)});
        endcase
    endtask

    // Assert reset just after a falling edge, check the cleared outputs,
    // and release it just after the next rising edge
    task automatic applyReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_ctrl", obs_ctrl, 0);
        checkOutput("rst_state", obs_state, 0);
        checkOutput("rst_illegal", obs_illegal, 0);
        checkOutput("rst_retired", obs_retired, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_retired = 0;
    endtask

    // Play the prepared sequence, checking every cycle. A reset is applied
    // in cycle abort_at when that index lies within the sequence.
    task automatic applyStimulus(input logic [5:0] opc, input int abort_at);
        int  ir_pulses;
        bit  rdy_eff;
        bit  trap;
        ir_pulses = 0;
        trap = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                applyReset();
                return;
            end
            mem_ready = seq[i].rdy;
            op = (seq[i].code == 0) ? 6'($urandom) : opc;
            #1;
            rdy_eff = use_b ? 1'b1 : seq[i].rdy;
            if (seq[i].code == 15) trap = 1'b1;
            checkOutput($sformatf("state op=%0h cyc=%0d", opc, i), obs_state, seq[i].code);
            checkOutput($sformatf("ctrl op=%0h cyc=%0d", opc, i), obs_ctrl,
                        exp_ctrl(seq[i].code, rdy_eff));
            checkOutput($sformatf("illegal op=%0h cyc=%0d", opc, i), obs_illegal,
                        (seq[i].code == 15) ? 1 : 0);
            checkOutput($sformatf("retired op=%0h cyc=%0d", opc, i), obs_retired,
                        model_retired);
            if (obs_ir_wr) ir_pulses++;
            @(posedge clk);
        end
        checkOutput($sformatf("irwr_pulses op=%0h", opc), ir_pulses, 1);
        if (!trap) begin
            model_retired = use_b ? ((model_retired + 1) % 16) : (model_retired + 1);
        end
    endtask

    function automatic logic [5:0] rand_legal_op();
        logic [5:0] ops [6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        return ops[$urandom_range(0, 5)];
    endfunction

    initial begin
        logic [5:0] opc;
        rst = 1'b1;
        mem_ready = 1'b0;
        op = 6'd0;
        use_b = 1'b0;
        model_retired = 0;

        @(negedge clk);
        applyReset();

        // R-type, no waits: states 0,1,6,7
        buildSequence(OP_R, 0, 0);
        applyStimulus(OP_R, -1);

        // LW with 2 FETCH waits and 3 MRD waits: 10 cycles
        buildSequence(OP_LW, 2, 3);
        applyStimulus(OP_LW, -1);

        // Back-to-back SW, BEQ, J, ADDI without waits
        buildSequence(OP_SW, 0, 0);
        applyStimulus(OP_SW, -1);
        buildSequence(OP_BEQ, 0, 0);
        applyStimulus(OP_BEQ, -1);
        buildSequence(OP_J, 0, 0);
        applyStimulus(OP_J, -1);
        buildSequence(OP_ADDI, 0, 0);
        applyStimulus(OP_ADDI, -1);

        // Illegal opcode traps for 20 cycles, then reset recovers
        buildSequence(OP_BAD, 0, 0);
        applyStimulus(OP_BAD, -1);
        @(negedge clk);
        applyReset();

        // Reset in the middle of an MRD wait, then a clean instruction
        buildSequence(OP_LW, 0, 3);
        applyStimulus(OP_LW, 4);
        buildSequence(OP_R, 0, 0);
        applyStimulus(OP_R, -1);

        // Random legal instructions with random wait lengths
        for (int n = 0; n < 40; n++) begin
            opc = rand_legal_op();
            buildSequence(opc, $urandom_range(0, 3), $urandom_range(0, 3));
            applyStimulus(opc, -1);
        end

        // Handshake disabled, mem_ready tied low, 4-bit counter wraps at 16
        use_b = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        applyReset();
        for (int n = 0; n < 16; n++) begin
            opc = (n == 0) ? OP_LW : rand_legal_op();
            buildSequence(opc, 0, 0);
            applyStimulus(opc, -1);
        end
        @(negedge clk);
        #1;
        checkOutput("wrap_retired", obs_retired, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
